// File: rtl/bob_retire_sched.sv
// Retirement scheduler for the branch-order buffer ring: tracks completion, reads the head
// entry from the bob RAM, presents it to the retire stage and pulses do_retire on acceptance.
module bob_retire_sched #(
  parameter int unsigned COUNT = 48,
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 65,
  parameter int unsigned SW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          except,
  input  logic [AW-1:0] flush_addr,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic          cmpl_en,
  input  logic [AW-1:0] cmpl_addr,
  input  logic          has_retire,
  output logic          ram_read_clkEn,
  output logic [AW-1:0] ram_read_addr,
  input  logic [DW-1:0] ram_read_data,
  output logic          do_retire,
  output logic          ret_valid,
  output logic [DW-1:0] ret_data,
  output logic [AW-1:0] ret_addr,
  input  logic          ret_ready,
  output logic [SW-1:0] ret_count
);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e           state_q;
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    head_nxt;
  logic [COUNT-1:0] done_q;
  logic [COUNT-1:0] done_d;
  logic [SW-1:0]    ret_count_q;
  logic             head_done;

  // Address compares instead of direct indexing keep out-of-range addresses harmless.
  always_comb begin
    head_done = 1'b0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      if (head_q == AW'(i)) head_done = done_q[i];
    end
  end

  assign ram_read_addr  = head_q;
  assign ram_read_clkEn = (state_q == StIdle) & has_retire & head_done & ~except;
  assign ret_valid      = (state_q == StRead) & ~except;
  assign do_retire      = ret_valid & ret_ready;
  assign ret_addr       = head_q;
  assign ret_data       = ram_read_data;
  assign ret_count      = ret_count_q;
  assign head_nxt       = (head_q == AW'(COUNT - 1)) ? '0 : head_q + AW'(1);

  // Allocation beats completion on the same address; retirement clears the head last.
  always_comb begin
    done_d = done_q;
    for (int unsigned i = 0; i < COUNT; i++) begin
      if (cmpl_en && cmpl_addr == AW'(i))   done_d[i] = 1'b1;
      if (alloc_en && alloc_addr == AW'(i)) done_d[i] = 1'b0;
      if (do_retire && head_q == AW'(i))    done_d[i] = 1'b0;
    end
    if (except) done_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      head_q      <= '0;
      done_q      <= '0;
      ret_count_q <= '0;
    end else begin
      done_q <= done_d;
      if (except) begin
        state_q <= StIdle;
        head_q  <= flush_addr;
      end else begin
        unique case (state_q)
          StIdle: if (ram_read_clkEn) state_q <= StRead;
          StRead: begin
            if (do_retire) begin
              state_q <= StIdle;
              head_q  <= head_nxt;
              if (ret_count_q != {SW{1'b1}}) ret_count_q <= ret_count_q + SW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bob_retire_sched.sv
// Directed bench for bob_retire_sched with an entry-level ring model checked every cycle.
module tb_bob_retire_sched;
  localparam int N    = 48;
  localparam int AW   = 6;
  localparam int DW   = 65;
  localparam int SW   = 4;
  localparam int SATV = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic except = 1'b0;
  logic [AW-1:0] flush_addr = '0;
  logic alloc_en = 1'b0;
  logic [AW-1:0] alloc_addr = '0;
  logic cmpl_en = 1'b0;
  logic [AW-1:0] cmpl_addr = '0;
  logic has_retire = 1'b0;
  logic ram_read_clkEn;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_read_data;
  logic do_retire, ret_valid, ret_ready;
  logic [DW-1:0] ret_data;
  logic [AW-1:0] ret_addr;
  logic [SW-1:0] ret_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bob_retire_sched #(.COUNT(N), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .except(except), .flush_addr(flush_addr),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .cmpl_en(cmpl_en), .cmpl_addr(cmpl_addr),
    .has_retire(has_retire), .ram_read_clkEn(ram_read_clkEn), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data), .do_retire(do_retire), .ret_valid(ret_valid),
    .ret_data(ret_data), .ret_addr(ret_addr), .ret_ready(ret_ready), .ret_count(ret_count)
  );

  function automatic logic [DW-1:0] ent(int a);
    return {1'(a & 1), 32'(a) * 32'h0101_0101, 32'hDEAD_0000 | 32'(a)};
  endfunction

  // RAM: registered read, output holds while the capture enable is low.
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) if (ram_read_clkEn) ram_q <= ent(int'(ram_read_addr));
  assign ram_read_data = ram_q;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ring model: head pointer, per-entry done flags, whether head is being presented.
  int m_head = 0;
  bit m_pres = 1'b0;
  int m_count = 0;
  bit m_done [N];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_head = 0; m_pres = 1'b0; m_count = 0;
      foreach (m_done[i]) m_done[i] = 1'b0;
    end else if (except) begin
      m_head = int'(flush_addr); m_pres = 1'b0;
      foreach (m_done[i]) m_done[i] = 1'b0;
    end else begin
      bit fire, start;
      fire  = m_pres && ret_ready;
      start = !m_pres && has_retire && m_done[m_head];
      if (cmpl_en && int'(cmpl_addr) < N) m_done[cmpl_addr] = 1'b1;
      if (alloc_en && int'(alloc_addr) < N) m_done[alloc_addr] = 1'b0;
      if (fire) begin
        m_done[m_head] = 1'b0;
        m_head = (m_head + 1) % N;
        m_count = (m_count < SATV) ? m_count + 1 : SATV;
        m_pres = 1'b0;
      end else if (start) m_pres = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bit e_valid;
      e_valid = m_pres && !except;
      chk("m_valid", ret_valid, e_valid);
      chk("m_do_retire", do_retire, e_valid && ret_ready);
      chk("m_clken", ram_read_clkEn, !m_pres && has_retire && m_done[m_head] && !except);
      chk("m_rd_addr", ram_read_addr, m_head);
      chk("m_count", ret_count, m_count);
      if (e_valid) begin
        chk("m_ret_addr", ret_addr, m_head);
        chk("m_ret_data", ret_data, ent(m_head));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    ret_ready = 1'b0;
    #3;
    chk("rst_valid", ret_valid, 0);
    chk("rst_do", do_retire, 0);
    chk("rst_clken", ram_read_clkEn, 0);
    chk("rst_addr", ram_read_addr, 0);
    chk("rst_count", ret_count, 0);
    step(); step();
    rst = 1'b1;

    // In-order presentation: entry 1 completes first but waits for entry 0.
    alloc_en = 1; alloc_addr = 0; step();
    alloc_addr = 1; step();
    alloc_addr = 2; step();
    alloc_en = 0; cmpl_en = 1; cmpl_addr = 1; has_retire = 1; step();
    cmpl_en = 0; step();
    chk("t1_wait_valid", ret_valid, 0);
    chk("t1_wait_clken", ram_read_clkEn, 0);
    cmpl_en = 1; cmpl_addr = 0; step();
    cmpl_en = 0;
    chk("t1_clken", ram_read_clkEn, 1);
    chk("t1_not_yet", ret_valid, 0);
    ret_ready = 1; step();
    chk("t1_valid0", ret_valid, 1);
    chk("t1_addr0", ret_addr, 0);
    chk("t1_data0", ret_data, ent(0));
    chk("t1_do0", do_retire, 1);
    step();
    chk("t1_rd1", ram_read_addr, 1);
    step();
    chk("t1_addr1", ret_addr, 1);
    chk("t1_do1", do_retire, 1);
    step();
    chk("t1_head2", ram_read_addr, 2);
    chk("t1_count2", ret_count, 2);

    // Back-pressure: hold the head for five cycles.
    ret_ready = 0; cmpl_en = 1; cmpl_addr = 2; step();
    cmpl_en = 0; step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", ret_valid, 1);
      chk("t2_hold_do", do_retire, 0);
      chk("t2_hold_data", ret_data, ent(2));
      step();
    end
    ret_ready = 1; #1;
    chk("t2_do", do_retire, 1);
    step();
    chk("t2_do_once", do_retire, 0);
    chk("t2_count3", ret_count, 3);

    // Same-cycle alloc and completion of entry 5: alloc wins.
    cmpl_en = 1; cmpl_addr = 3; step();
    cmpl_addr = 4; step();
    cmpl_en = 0; repeat (4) step();
    chk("t4_head5", ram_read_addr, 5);
    alloc_en = 1; alloc_addr = 5; cmpl_en = 1; cmpl_addr = 5; step();
    alloc_en = 0; cmpl_en = 0; repeat (3) step();
    chk("t4_no_valid", ret_valid, 0);
    chk("t4_no_clken", ram_read_clkEn, 0);
    cmpl_en = 1; cmpl_addr = 5; step();
    cmpl_en = 0; step(); step();
    chk("t4_head6", ram_read_addr, 6);
    chk("t4_count6", ret_count, 6);

    // Stale completion without occupancy must not start a read.
    has_retire = 0; cmpl_en = 1; cmpl_addr = 6; step();
    cmpl_en = 0; step();
    chk("stale_clken", ram_read_clkEn, 0);
    has_retire = 1; step(); step();
    chk("stale_head7", ram_read_addr, 7);

    // Flush while presenting.
    ret_ready = 0; cmpl_en = 1; cmpl_addr = 20; step();
    cmpl_addr = 21; step();
    cmpl_addr = 7; step();
    cmpl_en = 0; step();
    chk("t5_presenting", ret_valid, 1);
    except = 1; flush_addr = 20; ret_ready = 1; #1;
    chk("t5_valid_drop", ret_valid, 0);
    chk("t5_no_do", do_retire, 0);
    step();
    except = 0;
    chk("t5_head20", ram_read_addr, 20);
    chk("t5_count7", ret_count, 7);
    chk("t5_done_cleared", ram_read_clkEn, 0);

    // Wrap from 47 to 0; out-of-range completion is ignored.
    except = 1; flush_addr = 47; step();
    except = 0; cmpl_en = 1; cmpl_addr = 47; step();
    cmpl_en = 0;
    chk("t3_clken47", ram_read_clkEn, 1);
    step();
    chk("t3_addr47", ret_addr, 47);
    step();
    chk("t3_wrap", ram_read_addr, 0);
    cmpl_en = 1; cmpl_addr = 0; step();
    cmpl_addr = 50; step();
    cmpl_en = 0;
    chk("t3_valid0", ret_valid, 1);
    chk("t3_addr0", ret_addr, 0);
    step();
    chk("t3_count9", ret_count, 9);

    // Asynchronous reset in the middle of a presentation.
    ret_ready = 0; cmpl_en = 1; cmpl_addr = 1; step();
    cmpl_en = 0; step();
    chk("t6_presenting", ret_valid, 1);
    #2 rst = 0; #1;
    chk("t6_valid_rst", ret_valid, 0);
    chk("t6_do_rst", do_retire, 0);
    chk("t6_head_rst", ram_read_addr, 0);
    chk("t6_count_rst", ret_count, 0);
    @(posedge clk); #1 rst = 1;
    ret_ready = 1;
    for (int i = 0; i < 17; i++) begin
      cmpl_en = 1; cmpl_addr = AW'(i); step();
    end
    cmpl_en = 0;
    repeat (40) step();
    chk("t6_sat", ret_count, 15);
    chk("t6_head17", ram_read_addr, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bob_retire_sched.md
Name: bob_retire_sched

Overview:
- Retirement scheduler for the 48-entry branch-order buffer ring.
- Tracks per-entry completion, sequences reads of the bob RAM at the ring head, presents head entries in order to the retire consumer, and pulses doRetire toward the bob address allocator.
- Mirrors the allocator head pointer and flushes on exception.
- Sits between the bob allocator/RAM and the retire stage.

Parameters:
COUNT, 48, ring entries; the ring wraps at COUNT-1.
AW, 6, entry address width.
DW, 65, bob entry data width.
SW, 16, width of the retired-entry statistics counter.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  asynchronous, active-low reset; asserted when 0.
except  in  1  flush; synchronous, level-sampled.
flush_addr  in  AW  allocator new_addr; becomes the head on except.
alloc_en  in  1  entry allocated this cycle (already qualified by allocator stall).
alloc_addr  in  AW  address being allocated.
cmpl_en  in  1  writeback completion strobe.
cmpl_addr  in  AW  completed entry address.
has_retire  in  1  allocator reports occupancy != 0.
ram_read_clkEn  out  1  bob RAM read address capture enable.
ram_read_addr  out  AW  bob RAM read address.
ram_read_data  in  DW  bob RAM data; valid the cycle after capture.
do_retire  out  1  one-cycle pulse; the allocator advances its retire pointer.
ret_valid  out  1  head entry presented.
ret_data  out  DW  presented entry.
ret_addr  out  AW  address of the presented entry.
ret_ready  in  1  consumer accepts.
ret_count  out  SW  saturating count of retired entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, head=0, done[COUNT-1:0]=0, ret_count=0.
  - ret_valid=0, do_retire=0, ram_read_clkEn=0, ram_read_addr=0.
- done bitmap, per cycle:
  - alloc_en clears done[alloc_addr].
  - cmpl_en sets done[cmpl_addr].
  - Same address in the same cycle: alloc wins (bit cleared).
  - A retire handshake clears done[head].
- FSM states: IDLE, READ.
  - ram_read_addr = head at all times.
  - IDLE: ram_read_clkEn = has_retire & done[head]. If it is 1, go to READ next cycle.
  - READ: ret_valid=1, ret_data=ram_read_data, ret_addr=head.
    - If ret_ready=1: do_retire=1 (combinational, same cycle), clear done[head], advance head (head==COUNT-1 -> 0, else head+1), increment ret_count (saturating at all-ones), go to IDLE.
    - If ret_ready=0: hold READ. ret_data must stay stable; ram_read_clkEn=0 in READ.
- Timing:
  - Minimum latency from done[head] set (registered) to ret_valid is 1 cycle.
  - Throughput is 1 retire per 2 cycles; back-to-back chaining is not required.
- Completion of head while in READ: no effect on the presented entry.
- except=1, overriding everything except reset, same cycle:
  - ret_valid=0, do_retire=0, ram_read_clkEn=0.
  - Next edge: state=IDLE, head=flush_addr, all done bits cleared. alloc_en/cmpl_en in that cycle are ignored.
  - ret_count is preserved.
- has_retire=0 with done[head]=1 (stale completion) does not start a read.
- cmpl_addr/alloc_addr >= COUNT: ignored.
- Reset asserted mid-READ: immediate return to reset values; no do_retire pulse.

Test Plan:
1. Reset, alloc addrs 0,1,2, cmpl 1 then 0 -> no ret_valid until cmpl 0. Entry 0 is presented with ret_addr=0 one cycle after done[0]; with ret_ready=1 then entry 1 -> do_retire pulses 2, ret_count=2, head=2.
2. Head presented with ret_ready=0 for 5 cycles -> ret_valid held, ret_data stable, no do_retire. On ready -> exactly one do_retire pulse.
3. Wrap: head=47, entry 47 done, retired -> head=0; entry 0 done -> presented with ret_addr=0.
4. Simultaneous alloc_en and cmpl_en both at addr 5 -> done[5]=0. Entry 5 is not retired until a later cmpl 5.
5. except during READ with flush_addr=20 -> ret_valid drops same cycle, no do_retire, head=20, all done bits 0, ret_count unchanged.
6. rst asserted asynchronously mid-cycle in READ -> ret_valid=0 immediately. After release, head=0 and ret_count=0. Saturation check: with SW=4, 17 retires -> ret_count=15.
